doodle_physics: RTL
===================

DOODLE_PHYSICS -- requirements
Module: doodle_physics

Interface
REQ-001 SHALL take parameter NUM_PLAT, default 16: number of platform slots checked for landing.
REQ-002 SHALL take parameter NUM_SHOTS, default 4: number of independent projectile slots.
REQ-003 SHALL take parameters JUMP_V=12, GRAVITY=1, MAX_FALL=10, X_SPEED=2, SHOT_SPEED=7, DOODLE_S=12, PLAT_HW=16, SCREEN_W=640, SCREEN_H=480.
REQ-004 Clk  in  1  single system clock; all state SHALL change only on posedge Clk.
REQ-005 Reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-006 frame_tick  in  1  one-Clk pulse per video frame; the physics step SHALL occur only on cycles where it is high.
REQ-007 run  in  1  1 = play, 0 = pause (from AIR) or return to IDLE (from DEAD).
REQ-008 keycode  in  8  current key: 7/79 right, 4/80 left, 30 fire.
REQ-009 plat_x, plat_y  in  10*NUM_PLAT each  packed platform centre X / top Y, slot i at bits [10i+9:10i].
REQ-010 plat_valid  in  NUM_PLAT  slot i participates in collision only when bit i = 1.
REQ-011 doodle_x, doodle_y  out  10  doodle centre X / top Y; doodle_s out 10 = DOODLE_S.
REQ-012 vel_y  out  8  signed vertical velocity, positive = down.
REQ-013 shot_x, shot_y  out  10*NUM_SHOTS  packed projectile positions; shot_active out NUM_SHOTS.
REQ-014 landed  out  1  one-Clk pulse on a platform landing; land_idx out $clog2(NUM_PLAT), index of the landing platform.
REQ-015 fell  out  1  one-Clk pulse on entering DEAD; phase out 2: 00 IDLE, 01 AIR, 10 DEAD.

Function
REQ-016 SHALL implement states IDLE, AIR, DEAD; in IDLE, doodle SHALL be at (320,240) with vel_y=0.
REQ-017 IDLE -> AIR on frame_tick with run=1; vel_y SHALL be set to -JUMP_V.
REQ-018 In AIR, on frame_tick with run=0, all positions and velocities SHALL hold (pause).
REQ-019 In AIR, on frame_tick with run=1: next_vy = min(vel_y+GRAVITY, MAX_FALL); next_y = doodle_y + next_vy, computed in 11-bit signed.
REQ-020 Landing SHALL occur only when next_vy > 0, plat_valid[i]=1, doodle_y+DOODLE_S <= plat_y[i], next_y+DOODLE_S >= plat_y[i], and |doodle_x - plat_x[i]| <= PLAT_HW.
REQ-021 If several platforms qualify, the lowest index SHALL win.
REQ-022 On landing: doodle_y = plat_y[i]-DOODLE_S; vel_y = -JUMP_V; landed=1 for one Clk; land_idx=i.
REQ-023 With no landing, if next_y+DOODLE_S >= SCREEN_H-1: doodle_y = SCREEN_H-1-DOODLE_S, vel_y=0, go to DEAD, fell=1 for one Clk.
REQ-024 If next_y < 0, doodle_y SHALL clamp to 0 and vel_y SHALL be kept.
REQ-025 X motion: +X_SPEED for key 7/79, -X_SPEED for key 4/80, 0 otherwise.
REQ-026 X wrap SHALL be exact modulo: x<0 -> x+SCREEN_W; x>=SCREEN_W -> x-SCREEN_W.
REQ-027 Fire SHALL trigger only on the tick where keycode==30 and the previous tick's keycode !=30.
REQ-028 On fire, the lowest-index inactive shot slot SHALL take (doodle_x, doodle_y) from before the update; if all slots are active, the fire SHALL be dropped.
REQ-029 Each active shot SHALL move up by SHOT_SPEED per AIR run tick.
REQ-030 A shot SHALL deactivate when shot_y < SHOT_SPEED; deactivation and re-fire into that slot SHALL NOT occur on the same tick.
REQ-031 Landing, fire and wrap on the same tick SHALL all take effect.
REQ-032 DEAD SHALL freeze everything; on frame_tick with run=0 go to IDLE and clear all shots.

Reset
REQ-033 On Reset: phase=IDLE, doodle (320,240), vel_y=0, all shot_active=0, shot positions 0, landed=fell=0, land_idx=0, previous keycode=0.
REQ-034 Reset mid-frame or mid-jump SHALL abort immediately, with no pulse emitted.

Verification
V1 Reset, run=1, one tick -> phase=AIR, vel_y=-12, doodle_y=240 after the transition tick.
V2 Platform 3 at (320,300), valid; rise then fall -> landed pulse, land_idx=3, doodle_y=288, vel_y=-12.
V3 Platforms 2 and 5 both qualify on the same tick -> land_idx=2.
V4 doodle_x=639, key 7, one tick -> doodle_x=1; doodle_x=1, key 4 -> 639.
V5 Five fire presses with NUM_SHOTS=4 -> four slots active, fifth dropped; holding key 30 fires once only.
V6 No platforms, fall -> doodle_y=467, fell pulse, phase=DEAD; run=0 tick -> IDLE, shots cleared.

Source files
------------

// File: rtl/doodle_physics_if.sv
// Frame-level control, platform table and game-state outputs of the doodle physics engine.
interface doodle_physics_if #(
    parameter int NUM_PLAT  = 16,
    parameter int NUM_SHOTS = 4
);
    localparam int LW = (NUM_PLAT > 1) ? $clog2(NUM_PLAT) : 1;

    logic                     frame_tick;
    logic                     run;
    logic [7:0]               keycode;
    logic [10*NUM_PLAT-1:0]   plat_x;
    logic [10*NUM_PLAT-1:0]   plat_y;
    logic [NUM_PLAT-1:0]      plat_valid;
    logic [9:0]               doodle_x;
    logic [9:0]               doodle_y;
    logic [9:0]               doodle_s;
    logic [7:0]               vel_y;
    logic [10*NUM_SHOTS-1:0]  shot_x;
    logic [10*NUM_SHOTS-1:0]  shot_y;
    logic [NUM_SHOTS-1:0]     shot_active;
    logic                     landed;
    logic [LW-1:0]            land_idx;
    logic                     fell;
    logic [1:0]               phase;

    modport master (
        output frame_tick, run, keycode, plat_x, plat_y, plat_valid,
        input  doodle_x, doodle_y, doodle_s, vel_y, shot_x, shot_y, shot_active,
        input  landed, land_idx, fell, phase
    );

    modport slave (
        input  frame_tick, run, keycode, plat_x, plat_y, plat_valid,
        output doodle_x, doodle_y, doodle_s, vel_y, shot_x, shot_y, shot_active,
        output landed, land_idx, fell, phase
    );
endinterface

// File: rtl/doodle_physics.sv
// Per-frame doodle jump physics: gravity, platform landing, screen wrap, death floor and projectiles.
module doodle_physics #(
    parameter int NUM_PLAT   = 16,
    parameter int NUM_SHOTS  = 4,
    parameter int JUMP_V     = 12,
    parameter int GRAVITY    = 1,
    parameter int MAX_FALL   = 10,
    parameter int X_SPEED    = 2,
    parameter int SHOT_SPEED = 7,
    parameter int DOODLE_S   = 12,
    parameter int PLAT_HW    = 16,
    parameter int SCREEN_W   = 640,
    parameter int SCREEN_H   = 480
) (
    input  logic            Clk,
    input  logic            Reset,
    doodle_physics_if.slave bus
);
    localparam int LW = (NUM_PLAT > 1) ? $clog2(NUM_PLAT) : 1;

    localparam logic signed [8:0]  P_GRAV   = 9'(GRAVITY);
    localparam logic signed [8:0]  P_MAXF   = 9'(MAX_FALL);
    localparam logic signed [7:0]  P_JUMP   = 8'(-JUMP_V);
    localparam logic signed [11:0] P_S      = 12'(DOODLE_S);
    localparam logic signed [11:0] P_HW     = 12'(PLAT_HW);
    localparam logic signed [11:0] P_W      = 12'(SCREEN_W);
    localparam logic signed [11:0] P_FLOOR  = 12'(SCREEN_H - 1);
    localparam logic signed [11:0] P_XS     = 12'(X_SPEED);
    localparam logic [9:0]         P_SS     = 10'(SHOT_SPEED);
    localparam logic [9:0]         P_DEAD_Y = 10'(SCREEN_H - 1 - DOODLE_S);
    localparam logic [9:0]         P_HOME_X = 10'd320;
    localparam logic [9:0]         P_HOME_Y = 10'd240;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        AIR  = 2'b01,
        DEAD = 2'b10
    } state_t;

    state_t                  r_state, w_state_nxt;
    logic [9:0]              r_x, w_x_nxt;
    logic [9:0]              r_y, w_y_nxt;
    logic signed [7:0]       r_vy, w_vy_nxt;
    logic [10*NUM_SHOTS-1:0] r_shot_x, w_shot_x_nxt;
    logic [10*NUM_SHOTS-1:0] r_shot_y, w_shot_y_nxt;
    logic [NUM_SHOTS-1:0]    r_shot_act, w_shot_act_nxt;
    logic                    r_landed, w_landed_nxt;
    logic                    r_fell, w_fell_nxt;
    logic [LW-1:0]           r_land_idx, w_land_idx_nxt;
    logic [7:0]              r_prev_key, w_prev_key_nxt;

    logic signed [8:0]       w_vy_sum;
    logic signed [7:0]       w_vy_step;
    logic signed [11:0]      w_ny;
    logic signed [11:0]      w_cur_bot;
    logic signed [11:0]      w_nxt_bot;
    logic signed [11:0]      w_x_step;
    logic signed [11:0]      w_x_sum;
    logic [9:0]              w_x_wrap;
    logic [NUM_PLAT-1:0]     w_hit;
    logic                    w_land_any;
    logic [LW-1:0]           w_land_sel;
    logic [9:0]              w_land_py;
    logic [NUM_SHOTS-1:0]    w_free_oh;
    logic                    w_fire;

    assign w_vy_sum  = $signed({r_vy[7], r_vy}) + P_GRAV;
    assign w_vy_step = (w_vy_sum > P_MAXF) ? P_MAXF[7:0] : w_vy_sum[7:0];
    assign w_ny      = $signed({2'b00, r_y}) + $signed({{4{w_vy_step[7]}}, w_vy_step});
    assign w_cur_bot = $signed({2'b00, r_y}) + P_S;
    assign w_nxt_bot = w_ny + P_S;

    assign w_x_step = ((bus.keycode == 8'd7) || (bus.keycode == 8'd79)) ? P_XS :
                      ((bus.keycode == 8'd4) || (bus.keycode == 8'd80)) ? -P_XS : 12'sd0;
    assign w_x_sum  = $signed({2'b00, r_x}) + w_x_step;
    assign w_x_wrap = (w_x_sum < 12'sd0) ? 10'(w_x_sum + P_W) :
                      (w_x_sum >= P_W)   ? 10'(w_x_sum - P_W) : w_x_sum[9:0];

    // Edge-detected fire: a held key produces a single shot.
    assign w_fire = (bus.keycode == 8'd30) && (r_prev_key != 8'd30);

    for (genvar g = 0; g < NUM_PLAT; g++) begin : g_plat
        logic signed [11:0] w_py;
        logic signed [11:0] w_dx;
        logic signed [11:0] w_adx;
        assign w_py  = $signed({2'b00, bus.plat_y[10*g +: 10]});
        assign w_dx  = $signed({2'b00, r_x}) - $signed({2'b00, bus.plat_x[10*g +: 10]});
        assign w_adx = (w_dx < 12'sd0) ? -w_dx : w_dx;
        assign w_hit[g] = (w_vy_step > 8'sd0) && bus.plat_valid[g] &&
                          (w_cur_bot <= w_py) && (w_nxt_bot >= w_py) && (w_adx <= P_HW);
    end

    // Lowest qualifying platform index wins; lowest free shot slot takes a new shot.
    always_comb begin
        w_land_any = 1'b0;
        w_land_sel = '0;
        w_free_oh  = '0;
        for (int i = NUM_PLAT - 1; i >= 0; i--) begin
            w_land_sel = w_hit[i] ? LW'(i) : w_land_sel;
            w_land_any = w_land_any | w_hit[i];
        end
        for (int s = NUM_SHOTS - 1; s >= 0; s--) begin
            w_free_oh = r_shot_act[s] ? w_free_oh : (NUM_SHOTS'(1) << s);
        end
    end

    assign w_land_py = bus.plat_y[10*int'(w_land_sel) +: 10];

    // Next-state and physics step, taken only on frame ticks.
    always_comb begin
        w_state_nxt    = r_state;
        w_x_nxt        = r_x;
        w_y_nxt        = r_y;
        w_vy_nxt       = r_vy;
        w_shot_x_nxt   = r_shot_x;
        w_shot_y_nxt   = r_shot_y;
        w_shot_act_nxt = r_shot_act;
        w_landed_nxt   = 1'b0;
        w_fell_nxt     = 1'b0;
        w_land_idx_nxt = r_land_idx;
        w_prev_key_nxt = bus.frame_tick ? bus.keycode : r_prev_key;
        case (r_state)
            IDLE: begin
                if (bus.frame_tick && bus.run) begin
                    w_state_nxt = AIR;
                    w_vy_nxt    = P_JUMP;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            AIR: begin
                if (bus.frame_tick && bus.run) begin
                    w_x_nxt = w_x_wrap;
                    if (w_land_any) begin
                        w_y_nxt        = w_land_py - 10'(DOODLE_S);
                        w_vy_nxt       = P_JUMP;
                        w_landed_nxt   = 1'b1;
                        w_land_idx_nxt = w_land_sel;
                    end else if (w_nxt_bot >= P_FLOOR) begin
                        w_y_nxt     = P_DEAD_Y;
                        w_vy_nxt    = 8'sd0;
                        w_state_nxt = DEAD;
                        w_fell_nxt  = 1'b1;
                    end else if (w_ny < 12'sd0) begin
                        w_y_nxt  = 10'd0;
                        w_vy_nxt = w_vy_step;
                    end else begin
                        w_y_nxt  = w_ny[9:0];
                        w_vy_nxt = w_vy_step;
                    end
                    // A slot retiring this tick still reads as busy, so it cannot be refilled now.
                    for (int s = 0; s < NUM_SHOTS; s++) begin
                        if (r_shot_act[s]) begin
                            if (r_shot_y[10*s +: 10] < P_SS) begin
                                w_shot_act_nxt[s] = 1'b0;
                            end else begin
                                w_shot_y_nxt[10*s +: 10] = r_shot_y[10*s +: 10] - P_SS;
                            end
                        end else if (w_fire && w_free_oh[s]) begin
                            w_shot_act_nxt[s]        = 1'b1;
                            w_shot_x_nxt[10*s +: 10] = r_x;
                            w_shot_y_nxt[10*s +: 10] = r_y;
                        end else begin
                            w_shot_act_nxt[s] = 1'b0;
                        end
                    end
                end else begin
                    w_state_nxt = AIR;
                end
            end
            DEAD: begin
                if (bus.frame_tick && !bus.run) begin
                    w_state_nxt    = IDLE;
                    w_x_nxt        = P_HOME_X;
                    w_y_nxt        = P_HOME_Y;
                    w_vy_nxt       = 8'sd0;
                    w_shot_x_nxt   = '0;
                    w_shot_y_nxt   = '0;
                    w_shot_act_nxt = '0;
                end else begin
                    w_state_nxt = DEAD;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register with asynchronous reset to the idle pose.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state    <= IDLE;
            r_x        <= P_HOME_X;
            r_y        <= P_HOME_Y;
            r_vy       <= 8'sd0;
            r_shot_x   <= '0;
            r_shot_y   <= '0;
            r_shot_act <= '0;
            r_landed   <= 1'b0;
            r_fell     <= 1'b0;
            r_land_idx <= '0;
            r_prev_key <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_x        <= w_x_nxt;
            r_y        <= w_y_nxt;
            r_vy       <= w_vy_nxt;
            r_shot_x   <= w_shot_x_nxt;
            r_shot_y   <= w_shot_y_nxt;
            r_shot_act <= w_shot_act_nxt;
            r_landed   <= w_landed_nxt;
            r_fell     <= w_fell_nxt;
            r_land_idx <= w_land_idx_nxt;
            r_prev_key <= w_prev_key_nxt;
        end
    end

    assign bus.doodle_x    = r_x;
    assign bus.doodle_y    = r_y;
    assign bus.doodle_s    = 10'(DOODLE_S);
    assign bus.vel_y       = r_vy;
    assign bus.shot_x      = r_shot_x;
    assign bus.shot_y      = r_shot_y;
    assign bus.shot_active = r_shot_act;
    assign bus.landed      = r_landed;
    assign bus.land_idx    = r_land_idx;
    assign bus.fell        = r_fell;
    assign bus.phase       = r_state;
endmodule
